fft_address_calc: RTL and testbench
===================================

Name: fft_address_calc

Overview:
- Address generator that streams the word addresses of a memory-resident sample file to a downstream reader, in FFT input order.
- Within each full FFT frame, addresses are issued in bit-reversed index order.
- A trailing partial frame is issued in linear order.
- Sits between the data-control router's command interface (offset/filesize) and the sample memory read port; one address per clock unless paused.

Parameters:
- LOG2N, 6, log2 of FFT frame length in words (frame = 64 words).
- WORD_BYTES, 4, bytes per sample word; address stride. Power of two.
- AW, 32, width of offset, filesize and addr.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- offset  in  AW  byte base address of file; sampled on start.
- filesize  in  AW  file length in bytes; sampled on start.
- enable  in  1  level run request; deassertion aborts.
- pause  in  1  stall; holds all state while high.
- addr  out  AW  current byte address (registered).
- addr_valid  out  1  high in each cycle addr carries a new address.
- done  out  1  high once all addresses issued; held until enable low.

Behaviour:
- Reset (async):
  - state=IDLE.
  - addr=0, addr_valid=0, done=0.
  - All counters = 0.
- Word count: words = ceil(filesize/WORD_BYTES), computed with AW+1-bit intermediate; no overflow.
- Index mapping for word index k, with frame base f = k & ~(2^LOG2N-1):
  - Full frame (f + 2^LOG2N <= words): addr = offset + WORD_BYTES*(f + bitrev_LOG2N(k - f)).
  - Partial last frame: addr = offset + WORD_BYTES*k (linear).
  - Sum wraps modulo 2^AW.
- IDLE:
  - On a clock edge with enable=1 and pause=0: latch offset/words.
  - If words=0: go to DONE (done=1, addr_valid=0).
  - Otherwise emit index 0 in the same edge (addr=offset, addr_valid=1), k=1, go to RUN.
  - First address is therefore visible one cycle after enable is sampled.
- RUN, each edge with pause=0:
  - If k<words: emit index k, addr_valid=1, k++.
  - Otherwise: addr_valid=0, done=1, go to DONE; addr holds the last value.
- Timing: exactly `words` consecutive valid cycles absent pause; done rises on edge words+1.
- Pause=1 in any state:
  - No state, counter or addr change.
  - addr_valid forced 0 that cycle.
  - Resumes with the next index, never skipped or duplicated.
- enable=0 in RUN or DONE:
  - Next edge: go to IDLE, done=0, addr_valid=0, addr holds.
  - Abort takes priority over pause.
- DONE: done=1 held while enable=1; offset/filesize changes ignored until a pass through IDLE.
- offset/filesize changes during RUN are ignored (latched copies are used).
- Start requires IDLE; re-assertion of enable after abort restarts from index 0 with freshly sampled inputs.

Decomposition:
- Shared package fft_addr_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - LOG2N/WORD_BYTES defaults;
  - a bitrev function.
- One natural sub-module: fft_bitrev_index (combinational; k, frame-full flag -> word offset).
- Top holds the FSM, counters and output registers.

Test Plan:
- Reset mid-RUN (offset=0, filesize=10000, reset pulsed at cycle 100) -> addr=0, addr_valid=0, done=0 immediately, without waiting for a clock edge.
- offset=0, filesize=10000, enable held -> addresses 0,128,64,192,32,... for the first frame.
  - 2500 valid cycles.
  - Last four addresses 9984,9988,9992,9996 (linear tail).
  - done=1 on edge 2501.
- offset=100524, filesize=1000 -> first addresses 100524,100652,100588.
  - 250 valid cycles: 192 bit-reversed, then 58 linear ending at 101520.
  - done then high.
- Pause high for 5 cycles after the 10th address (offset=0, filesize=10000) -> addr frozen, addr_valid=0 during pause.
  - 11th address is the correct next index.
  - Total valid count still 2500.
- enable dropped after 1000 cycles, then after 6 cycles re-raised with offset=100524, filesize=1000 -> done never asserted for the first run; second run restarts at 100524.
- filesize=0 -> done=1 one cycle after enable, no valid addresses.
- filesize=3 -> one address, done next cycle.

Source files
------------

// File: rtl/fft_addr_pkg.sv
// rtl/fft_addr_pkg.sv - shared types, defaults and bit-reversal helper for the FFT address generator
package fft_addr_pkg;

  localparam int DEF_LOG2N      = 6;
  localparam int DEF_WORD_BYTES = 4;
  localparam int DEF_AW         = 32;
  localparam int MAX_LOG2N      = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Reverses the low n bits of v; bits above n come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v, input int n);
    logic [MAX_LOG2N-1:0] r;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      r[i] = v[MAX_LOG2N-1-i];
    end
    return r >> (MAX_LOG2N - n);
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// rtl/fft_bitrev_index.sv - maps a linear word index to its FFT-order word offset
module fft_bitrev_index
  import fft_addr_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int AW    = DEF_AW
) (
  input  logic [AW:0] k,
  input  logic        frame_full,
  output logic [AW:0] widx
);

  logic [LOG2N-1:0] rev;

  assign rev  = LOG2N'(bitrev(MAX_LOG2N'(k[LOG2N-1:0]), LOG2N));
  // Only complete frames are reordered; the trailing partial frame stays linear.
  assign widx = frame_full ? {k[AW:LOG2N], rev} : k;

endmodule

// File: rtl/fft_address_calc.sv
// rtl/fft_address_calc.sv - streams byte addresses of a sample file in FFT input order
module fft_address_calc
  import fft_addr_pkg::*;
#(
  parameter int LOG2N      = DEF_LOG2N,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int AW         = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] offset,
  input  logic [AW-1:0] filesize,
  input  logic          enable,
  input  logic          pause,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          done
);

  localparam int          WB_SHIFT   = $clog2(WORD_BYTES);
  localparam int          FRAME      = 1 << LOG2N;
  localparam logic [AW:0] FRAME_MASK = ~((AW+1)'(FRAME - 1));

  state_t        state;
  logic [AW-1:0] off_q;
  logic [AW:0]   words_q;
  logic [AW:0]   k_q;

  logic [AW:0]   words_in;
  logic [AW:0]   frame_base;
  logic          frame_full;
  logic [AW:0]   widx;
  logic [AW-1:0] byte_off;

  // One extra bit keeps the round-up from overflowing for filesize near 2^AW.
  assign words_in   = ({1'b0, filesize} + (AW+1)'(WORD_BYTES - 1)) >> WB_SHIFT;
  assign frame_base = k_q & FRAME_MASK;
  assign frame_full = (frame_base + (AW+1)'(FRAME)) <= words_q;
  assign byte_off   = AW'(widx << WB_SHIFT);

  fft_bitrev_index #(
    .LOG2N(LOG2N),
    .AW   (AW)
  ) u_bitrev (
    .k         (k_q),
    .frame_full(frame_full),
    .widx      (widx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      addr_valid <= 1'b0;
      done       <= 1'b0;
      off_q      <= '0;
      words_q    <= '0;
      k_q        <= '0;
    end else if (!enable) begin
      // Abort wins over pause; addr keeps its last value.
      state      <= IDLE;
      addr_valid <= 1'b0;
      done       <= 1'b0;
    end else if (pause) begin
      addr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          off_q   <= offset;
          words_q <= words_in;
          if (words_in == '0) begin
            state      <= DONE;
            addr_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            state      <= RUN;
            addr       <= offset;
            addr_valid <= 1'b1;
            k_q        <= (AW+1)'(1);
          end
        end
        RUN: begin
          if (k_q < words_q) begin
            addr       <= off_q + byte_off;
            addr_valid <= 1'b1;
            k_q        <= k_q + (AW+1)'(1);
          end else begin
            state      <= DONE;
            addr_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        DONE: begin
          addr_valid <= 1'b0;
          done       <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          addr_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_address_calc.sv
// tb/tb_fft_address_calc.sv - randomized self-checking bench for fft_address_calc
module tb_fft_address_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] offset;
  logic [31:0] filesize;
  logic        enable;
  logic        pause;
  logic [31:0] addr;
  logic        addr_valid;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  fft_address_calc dut (
    .clk       (clk),
    .reset     (reset),
    .offset    (offset),
    .filesize  (filesize),
    .enable    (enable),
    .pause     (pause),
    .addr      (addr),
    .addr_valid(addr_valid),
    .done      (done)
  );

  // Address of the k-th issued word, straight from the ordering rules.
  function automatic logic [31:0] ref_addr(input logic [31:0] off, input logic [31:0] fs, input longint k);
    longint words, base, r, rr, a;
    words = (longint'(fs) + 3) / 4;
    base  = (k / 64) * 64;
    r     = k - base;
    if (base + 64 <= words) begin
      rr = 0;
      for (int b = 0; b < 6; b++) begin
        rr = rr * 2 + (r % 2);
        r  = r / 2;
      end
    end else begin
      rr = r;
    end
    a = longint'(off) + 4 * (base + rr);
    return a[31:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; pause = 1'b0; offset = '0; filesize = '0;
    #1;
    total++; if (addr !== 32'd0)     begin bad++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", addr_valid); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    @(negedge clk);
    reset = 1'b0;
    offset = 32'd0; filesize = 32'd10000; enable = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (addr_valid !== 1'b1) begin bad++; $display("FAIL midrun_valid: got %0b expected 1", addr_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (addr !== 32'd0)     begin bad++; $display("FAIL async_reset_addr: got %0d expected 0", addr); end
    total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %0b expected 0", addr_valid); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL async_reset_done: got %0b expected 0", done); end
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);
  endtask

  // Runs one complete file, checking every issued address and the done timing.
  task automatic test_stream(input string name, input logic [31:0] off, input logic [31:0] fs, input bit do_pause);
    longint exp_words;
    longint n;
    int     cyc;
    bit     got_done;
    bit     prev_pause;
    exp_words = (longint'(fs) + 3) / 4;
    n = 0; cyc = 0; got_done = 0; prev_pause = 0;
    got_q.delete();
    offset = off; filesize = fs; pause = 1'b0; enable = 1'b1;
    while (!got_done && cyc < exp_words * 4 + 50) begin
      @(negedge clk);
      cyc++;
      if (prev_pause) begin
        total++;
        if (addr_valid !== 1'b0) begin bad++; $display("FAIL %s_pause_valid: got %0b expected 0 at cycle %0d", name, addr_valid, cyc); end
      end
      if (addr_valid === 1'b1) begin
        got_q.push_back(addr);
        total++;
        if (addr !== ref_addr(off, fs, n)) begin
          bad++; $display("FAIL %s_addr[%0d]: got %0d expected %0d", name, n, addr, ref_addr(off, fs, n));
        end
        n++;
      end
      if (done === 1'b1) got_done = 1;
      // Latched copies must be used: scramble the live inputs once running.
      if (cyc > 1) begin
        offset = $urandom; filesize = $urandom;
      end
      prev_pause = do_pause && ($urandom_range(0, 3) == 0);
      pause = prev_pause;
    end
    pause = 1'b0;
    total++; if (!got_done) begin bad++; $display("FAIL %s_done_timeout: got 0 expected 1 within %0d cycles", name, cyc); end
    total++; if (n != exp_words) begin bad++; $display("FAIL %s_count: got %0d expected %0d", name, n, exp_words); end
    if (!do_pause) begin
      total++; if (cyc != exp_words + 1) begin bad++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, cyc, exp_words + 1); end
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (done !== 1'b1 || addr_valid !== 1'b0) begin
        bad++; $display("FAIL %s_done_hold: got done=%0b valid=%0b expected done=1 valid=0", name, done, addr_valid);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      bad++; $display("FAIL %s_disable: got done=%0b valid=%0b expected 0 0", name, done, addr_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] first5[5] = '{32'd0, 32'd128, 32'd64, 32'd192, 32'd32};
    logic [31:0] last4[4]  = '{32'd9984, 32'd9988, 32'd9992, 32'd9996};
    test_stream("basic", 32'd0, 32'd10000, 1'b0);
    total++; if (got_q.size() != 2500) begin bad++; $display("FAIL basic_size: got %0d expected 2500", got_q.size()); end
    if (got_q.size() == 2500) begin
      for (int i = 0; i < 5; i++) begin
        total++; if (got_q[i] !== first5[i]) begin bad++; $display("FAIL basic_first[%0d]: got %0d expected %0d", i, got_q[i], first5[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        total++; if (got_q[2496+i] !== last4[i]) begin bad++; $display("FAIL basic_tail[%0d]: got %0d expected %0d", i, got_q[2496+i], last4[i]); end
      end
    end
  endtask

  task automatic test_offset();
    test_stream("offset", 32'd100524, 32'd1000, 1'b0);
    total++; if (got_q.size() != 250) begin bad++; $display("FAIL offset_size: got %0d expected 250", got_q.size()); end
    if (got_q.size() == 250) begin
      total++; if (got_q[0] !== 32'd100524) begin bad++; $display("FAIL offset_a0: got %0d expected 100524", got_q[0]); end
      total++; if (got_q[1] !== 32'd100652) begin bad++; $display("FAIL offset_a1: got %0d expected 100652", got_q[1]); end
      total++; if (got_q[2] !== 32'd100588) begin bad++; $display("FAIL offset_a2: got %0d expected 100588", got_q[2]); end
      total++; if (got_q[191] !== 32'd101288) begin bad++; $display("FAIL offset_a191: got %0d expected 101288", got_q[191]); end
      total++; if (got_q[192] !== 32'd101292) begin bad++; $display("FAIL offset_a192: got %0d expected 101292", got_q[192]); end
      total++; if (got_q[249] !== 32'd101520) begin bad++; $display("FAIL offset_last: got %0d expected 101520", got_q[249]); end
    end
  endtask

  task automatic test_pause();
    int n = 0;
    int cyc = 0;
    logic [31:0] held;
    offset = 32'd0; filesize = 32'd10000; pause = 1'b0; enable = 1'b1;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (addr_valid === 1'b1) begin
        total++; if (addr !== ref_addr(32'd0, 32'd10000, n)) begin bad++; $display("FAIL pause_addr[%0d]: got %0d expected %0d", n, addr, ref_addr(32'd0, 32'd10000, n)); end
        n++;
        if (n == 10) begin
          held = addr;
          pause = 1'b1;
          repeat (5) begin
            @(negedge clk);
            cyc++;
            total++;
            if (addr_valid !== 1'b0 || addr !== held) begin
              bad++; $display("FAIL pause_freeze: got valid=%0b addr=%0d expected valid=0 addr=%0d", addr_valid, addr, held);
            end
          end
          pause = 1'b0;
        end
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL pause_done: got %0b expected 1", done); end
    total++; if (n != 2500) begin bad++; $display("FAIL pause_count: got %0d expected 2500", n); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen_done = 0;
    offset = 32'd0; filesize = 32'd10000; pause = 1'b0; enable = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    enable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
      total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %0b expected 0", addr_valid); end
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL abort_done: got %0d done cycles expected 0", seen_done); end
    test_stream("restart", 32'd100524, 32'd1000, 1'b0);
    total++; if (got_q.size() == 0 || got_q[0] !== 32'd100524) begin bad++; $display("FAIL restart_first: got %0d entries expected first 100524", got_q.size()); end
  endtask

  task automatic test_small();
    test_stream("zero", 32'd5000, 32'd0, 1'b0);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL zero_size: got %0d expected 0", got_q.size()); end
    test_stream("three", 32'd5000, 32'd3, 1'b0);
    total++; if (got_q.size() != 1 || got_q[0] !== 32'd5000) begin bad++; $display("FAIL three_single: got %0d entries expected 1 at 5000", got_q.size()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      test_stream("rand", $urandom, 32'($urandom_range(0, 900)), t[0]);
    end
    test_stream("wrap", 32'hFFFF_FF00, 32'd1025, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_pause();
    test_abort();
    test_small();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
